// File: rtl/hilo_muldiv.sv
// hilo_muldiv
//   Holds the architectural HI/LO registers for the multi-cycle controller.
//   MTHI/MTLO write immediately. MULT/MULTU/DIV/DIVU run iteratively:
//   WIDTH shift-add or restoring shift-subtract steps on operand magnitudes,
//   followed by one sign-fix cycle that commits HI and LO together.
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous, active-high reset
//   HILOop   : operation code (0 = none, 1..6 below, 7 = undefined/no-op)
//   HILOwe   : command strobe, accepted only while busy is low
//   rs_data  : operand A (multiplicand / dividend / MTHI-MTLO source)
//   rt_data  : operand B (multiplier / divisor)
//   hi_out   : HI register
//   lo_out   : LO register
//   busy     : iterative operation in flight
//   done     : one-cycle pulse in the cycle after an iterative commit
//
// Build option
//   HILO_FAST_MUL_EN : when defined, MULT/MULTU finish at the accept edge
//                      using a combinational multiplier; DIV/DIVU stay iterative.

module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       HILOop,
  input  logic             HILOwe,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    counter;
  logic             accept;
  logic             is_mul, is_div, is_iter, is_signed;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  // Latched operation context for the iterative path
  logic             op_div, neg_q, neg_r, div_zero;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc_hi, acc_lo;

  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, hi_res, lo_res;

  assign accept    = HILOwe && (state == IDLE);
  assign busy      = (state != IDLE);
  assign is_mul    = (HILOop == OP_MULT) || (HILOop == OP_MULTU);
  assign is_div    = (HILOop == OP_DIV)  || (HILOop == OP_DIVU);
  assign is_signed = (HILOop == OP_MULT) || (HILOop == OP_DIV);

`ifdef HILO_FAST_MUL_EN
  assign is_iter = is_div;
`else
  assign is_iter = is_mul || is_div;
`endif

  // Two's complement negation of the most-negative value yields 2^(WIDTH-1),
  // which is exactly right when the result is read as an unsigned magnitude.
  assign neg_a = is_signed && rs_data[WIDTH-1];
  assign neg_b = is_signed && rt_data[WIDTH-1];
  assign mag_a = neg_a ? -rs_data : rs_data;
  assign mag_b = neg_b ? -rt_data : rt_data;

  // One iteration step. Multiply: the multiplier sits in acc_lo and shifts
  // out LSB-first while the partial product shifts into it from acc_hi.
  // Divide: acc_lo holds the dividend shifting out MSB-first and collects
  // quotient bits; acc_hi is the running remainder, and bit WIDTH of the
  // trial difference acts as the borrow.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
  end

  // Sign correction applied in FIX. Divide-by-zero forces an all-ones
  // quotient; the remainder path already reproduces the signed dividend.
  always_comb begin
    prod_mag = {acc_hi, acc_lo};
    prod_fix = neg_q ? -prod_mag : prod_mag;
    quo_fix  = div_zero ? '1 : (neg_q ? -acc_lo : acc_lo);
    rem_fix  = neg_r ? -acc_hi : acc_hi;
    if (op_div) begin
      hi_res = rem_fix;
      lo_res = quo_fix;
    end else begin
      hi_res = prod_fix[2*WIDTH-1:WIDTH];
      lo_res = prod_fix[WIDTH-1:0];
    end
  end

`ifdef HILO_FAST_MUL_EN
  // Sign-extending to 2*WIDTH makes the low 2*WIDTH product bits correct
  // for both signed and unsigned operands.
  logic [2*WIDTH-1:0] fast_a, fast_b, fast_prod;
  always_comb begin
    fast_a    = is_signed ? {{WIDTH{rs_data[WIDTH-1]}}, rs_data} : {{WIDTH{1'b0}}, rs_data};
    fast_b    = is_signed ? {{WIDTH{rt_data[WIDTH-1]}}, rt_data} : {{WIDTH{1'b0}}, rt_data};
    fast_prod = fast_a * fast_b;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && is_iter) state_next = RUN;
      RUN:     if (counter == LAST)   state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter  <= '0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      opb      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      hi_out   <= '0;
      lo_out   <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (HILOop == OP_MTHI) begin
              hi_out <= rs_data;
            end else if (HILOop == OP_MTLO) begin
              lo_out <= rs_data;
            end
`ifdef HILO_FAST_MUL_EN
            else if (is_mul) begin
              hi_out <= fast_prod[2*WIDTH-1:WIDTH];
              lo_out <= fast_prod[WIDTH-1:0];
            end
`endif
            if (is_iter) begin
              counter  <= '0;
              op_div   <= is_div;
              neg_q    <= neg_a ^ neg_b;
              neg_r    <= neg_a;
              div_zero <= is_div && (rt_data == '0);
              opb      <= mag_b;
              acc_hi   <= '0;
              acc_lo   <= mag_a;
            end
          end
        end
        RUN: begin
          counter <= (counter == LAST) ? '0 : counter + CW'(1);
          if (op_div) begin
            if (!div_diff[WIDTH]) begin
              acc_hi <= div_diff[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          hi_out <= hi_res;
          lo_out <= lo_res;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv
//   Directed bench for hilo_muldiv. Expected HI/LO pairs are queued when a
//   command is issued; a monitor pops and compares them whenever the DUT
//   commits a result (done pulse, or the edge after an immediate write).

module tb_hilo_muldiv;

  localparam int W = 32;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

`ifdef HILO_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   HILOop;
  logic         HILOwe;
  logic [W-1:0] rs_data, rt_data;
  logic [W-1:0] hi_out, lo_out;
  logic         busy, done;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  hilo_muldiv #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .HILOop  (HILOop),
    .HILOwe  (HILOwe),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .hi_out  (hi_out),
    .lo_out  (lo_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic bit isImmediate(input logic [2:0] op);
    return (op == OP_MTHI) || (op == OP_MTLO) ||
           (FAST && ((op == OP_MULT) || (op == OP_MULTU)));
  endfunction

  // Monitor: decides from the accept edge or the done pulse when a result
  // is visible, then compares it against the oldest queued expectation.
  initial begin
    bit   imm_seen;
    exp_t e;
    forever begin
      @(posedge clk);
      imm_seen = (rst === 1'b0) && HILOwe && !busy && isImmediate(HILOop);
      @(negedge clk);
      if (done === 1'b1 || imm_seen) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput({e.name, "_hi"}, hi_out, e.hi);
          checkOutput({e.name, "_lo"}, lo_out, e.lo);
        end
      end
    end
  end

  // Called at a negedge; holds the command for one edge, then scrambles the
  // operand buses so any late sampling of them shows up as a wrong result.
  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b);
    HILOop  = op;
    rs_data = a;
    rt_data = b;
    HILOwe  = 1'b1;
    @(negedge clk);
    HILOwe  = 1'b0;
    HILOop  = OP_NONE;
    rs_data = 32'hA5A5_A5A5;
    rt_data = 32'h5A5A_5A5A;
  endtask

  task automatic runImmediate(input logic [2:0] op, input logic [W-1:0] a,
                              input logic [W-1:0] ehi, input logic [W-1:0] elo,
                              input string name);
    exp_q.push_back('{ehi, elo, name});
    applyStimulus(op, a, 32'h0);
    checkOutput({name, "_busy0"}, {31'b0, busy}, 32'd0);
    @(negedge clk);
    checkOutput({name, "_busy1"}, {31'b0, busy}, 32'd0);
    checkOutput({name, "_done"}, {31'b0, done}, 32'd0);
  endtask

  task automatic runIter(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] ehi,
                         input logic [W-1:0] elo, input bit poke,
                         input string name);
    logic [W-1:0] prev_hi, prev_lo;
    int           cycles;
    bit           held;
    prev_hi = hi_out;
    prev_lo = lo_out;
    exp_q.push_back('{ehi, elo, name});
    applyStimulus(op, a, b);
    if (FAST && (op == OP_MULT || op == OP_MULTU)) begin
      checkOutput({name, "_fast_busy"}, {31'b0, busy}, 32'd0);
      @(negedge clk);
      checkOutput({name, "_fast_done"}, {31'b0, done}, 32'd0);
    end else begin
      cycles = 0;
      held   = 1'b1;
      while (busy && cycles < 100) begin
        if (hi_out !== prev_hi || lo_out !== prev_lo) held = 1'b0;
        if (poke && cycles == 5) begin
          HILOop  = OP_MTHI;
          rs_data = 32'h1111_1111;
          HILOwe  = 1'b1;
        end else begin
          HILOwe  = 1'b0;
          HILOop  = OP_NONE;
        end
        @(negedge clk);
        cycles++;
      end
      HILOwe = 1'b0;
      checkOutput({name, "_busy_cycles"}, cycles, W + 1);
      checkOutput({name, "_held"}, {31'b0, held}, 32'd1);
      checkOutput({name, "_done_pulse"}, {31'b0, done}, 32'd1);
      @(negedge clk);
      checkOutput({name, "_done_clear"}, {31'b0, done}, 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] h0, l0;
    rst     = 1'b1;
    HILOop  = OP_NONE;
    HILOwe  = 1'b0;
    rs_data = '0;
    rt_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_hi",   hi_out, 32'd0);
    checkOutput("reset_lo",   lo_out, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    runImmediate(OP_MTLO, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, "mtlo");
    runImmediate(OP_MTHI, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h1234_5678, "mthi");

    // Undefined code and op 0 with the strobe raised must not touch HI/LO
    h0 = hi_out;
    l0 = lo_out;
    applyStimulus(3'd7, 32'hFFFF_0000, 32'h1);
    applyStimulus(OP_NONE, 32'h0000_FFFF, 32'h1);
    checkOutput("noop_hi",   hi_out, h0);
    checkOutput("noop_lo",   lo_out, l0);
    checkOutput("noop_busy", {31'b0, busy}, 32'd0);

    runIter(OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, "mult_neg");
    runIter(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
    runIter(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, "mult_minneg");
    runIter(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg_dividend");
    runIter(OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, "div_neg_divisor");
    runIter(OP_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b0, "divu_by_zero");
    runIter(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, "div_by_zero");
    runIter(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b1, "div_overflow");

    // Reset in the middle of RUN aborts the divide and clears HI/LO
    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_hi",   hi_out, 32'd0);
    checkOutput("abort_lo",   lo_out, 32'd0);
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("abort_done_after", {31'b0, done}, 32'd0);

    runIter(OP_MULTU, 32'd6,   32'd7, 32'd0, 32'd42, 1'b0, "multu_after_reset");
    runIter(OP_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "divu_100_7");

    repeat (3) @(negedge clk);
    checkOutput("outstanding_expectations", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
